instruction_fetch: RTL and testbench

Fetch-side initiator for the instruction memory port. It owns the fetch PC and drives imem_req/imem_addr. Words returned on imem_data are captured into a small FIFO, which presents them to decode with a valid/ready handshake. The block handles branch/jump redirects from execute by flushing the FIFO and restarting at the target. It sits between the instruction memory and the decode stage.

---
 rtl/if_pkg.sv | 27 ++
 rtl/if_fifo.sv | 80 ++++++++
 rtl/instruction_fetch.sv | 133 +++++++++++++
 tb/tb_instruction_fetch.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
/******************************************************************************
 * Module   : if_pkg
 * Desc     : Shared types and constants for the instruction fetch block.
 * Revision : 1.0 - initial release
 ******************************************************************************/
`default_nettype none

package if_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] PC_STEP   = 32'd4;
    localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] pc;
        logic [INSTR_W-1:0] instr;
    } if_entry_t;

endpackage

`default_nettype wire

// File: rtl/if_fifo.sv
/******************************************************************************
 * Module   : if_fifo
 * Desc     : Prefetch buffer of {pc, instr} entries; push+pop allowed when full.
 * Revision : 1.0 - initial release
 ******************************************************************************/
`default_nettype none

module if_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_push,
    input  logic      i_pop,
    input  logic      i_flush,
    input  if_entry_t i_wdata,
    output if_entry_t o_rdata,
    output logic      o_full,
    output logic      o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    if_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty && !i_flush;
    // A full buffer only accepts a write when the head leaves in the same cycle
    assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_mem
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_mem[g] <= '0;
                end else if (w_do_push && (r_wr_ptr == PTR_W'(g))) begin
                    r_mem[g] <= i_wdata;
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
/******************************************************************************
 * Module   : instruction_fetch
 * Desc     : Fetch PC owner, imem request driver and prefetch FIFO to decode.
 *            Optional macro IFETCH_MISALIGN_CHK_EN adds the misaligned-redirect
 *            ERR state and misalign_err flag.
 * Revision : 1.0 - initial release
 ******************************************************************************/
`default_nettype none

module instruction_fetch
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_en,
    output logic               imem_req,
    output logic [INSTR_W-1:0] imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [INSTR_W-1:0] redirect_pc,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [INSTR_W-1:0] if_pc,
    input  logic               if_ready,
    output logic               misalign_err
);

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic [INSTR_W-1:0] r_fetch_pc;
    logic               r_out_live;
    logic [INSTR_W-1:0] w_redirect_target;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_run;
    if_entry_t          w_wdata;
    if_entry_t          w_head;

`ifdef IFETCH_MISALIGN_CHK_EN
    logic w_redirect_misaligned;
    logic r_misalign_err;

    assign w_redirect_misaligned = (redirect_pc[1:0] != 2'b00);
    assign w_redirect_target     = redirect_pc;
    assign misalign_err          = r_misalign_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign_err <= 1'b0;
        end else if (redirect_valid) begin
            r_misalign_err <= w_redirect_misaligned;
        end
    end
`else
    assign w_redirect_target = redirect_pc & ~32'h3;
    assign misalign_err      = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
`ifdef IFETCH_MISALIGN_CHK_EN
        // ERR is left only through an aligned redirect
        if (redirect_valid && w_redirect_misaligned) begin
            w_state_nxt = ERR;
        end else if (redirect_valid || (r_state != ERR)) begin
            w_state_nxt = fetch_en ? RUN : IDLE;
        end
`else
        w_state_nxt = fetch_en ? RUN : IDLE;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_run     = (r_state == RUN);
    assign w_pop     = !w_empty && if_ready;
    assign imem_req  = w_run && !redirect_valid && (!w_full || w_pop);
    assign imem_addr = r_fetch_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_fetch_pc <= w_redirect_target;
        end else if (imem_req) begin
            r_fetch_pc <= r_fetch_pc + PC_STEP;
        end
    end

    // Empty-head instr reads 0 only until the first edge out of reset, then NOP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_live <= 1'b0;
        end else begin
            r_out_live <= 1'b1;
        end
    end

    assign w_wdata.pc    = r_fetch_pc;
    assign w_wdata.instr = imem_data;

    if_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (imem_req),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_wdata (w_wdata),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign if_valid = !w_empty;
    assign if_pc    = w_empty ? '0 : w_head.pc;
    assign if_instr = !w_empty  ? w_head.instr :
                      r_out_live ? INSTR_NOP : '0;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
/******************************************************************************
 * Module   : tb_instruction_fetch
 * Desc     : Directed self-checking bench with a queue-based reference model.
 * Revision : 1.0 - initial release
 ******************************************************************************/
`default_nettype none

module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          FIFO_DEPTH = 2;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        misalign_err;

    int total;
    int bad;

    instruction_fetch #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_ready       (if_ready),
        .misalign_err   (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_2468;
    endfunction

    assign imem_data = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: fetch pc, run/err flags, queue of buffered pcs
    logic [31:0] m_pc;
    logic        m_run;
    logic        m_err;
    logic        m_started;
    logic [31:0] m_q[$];

    task automatic model_reset();
        m_pc      = RESET_PC;
        m_run     = 1'b0;
        m_err     = 1'b0;
        m_started = 1'b0;
        m_q.delete();
    endtask

    function automatic logic m_pop();
        return (m_q.size() != 0) && if_ready;
    endfunction

    function automatic logic m_req();
        return m_run && !m_err && !redirect_valid &&
               ((m_q.size() < FIFO_DEPTH) || m_pop());
    endfunction

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            logic req;
            logic pop;
            req = m_req();
            pop = m_pop();
            m_started = 1'b1;
            if (redirect_valid) begin
                m_q.delete();
`ifdef IFETCH_MISALIGN_CHK_EN
                m_pc  = redirect_pc;
                m_err = (redirect_pc[1:0] != 2'b00);
`else
                m_pc  = {redirect_pc[31:2], 2'b00};
`endif
                m_run = fetch_en;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (req) begin
                    m_q.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                end
                if (!m_err) m_run = fetch_en;
            end
        end
    end

    always @(negedge clk) begin
        logic        ev;
        logic [31:0] ep;
        logic [31:0] ei;
        ev = (m_q.size() != 0);
        ep = ev ? m_q[0] : 32'h0;
        ei = ev ? mem_word(m_q[0]) : (m_started ? NOP : 32'h0);
        chk("m_imem_req",  {31'b0, imem_req}, {31'b0, m_req()});
        chk("m_imem_addr", imem_addr, m_pc);
        chk("m_if_valid",  {31'b0, if_valid}, {31'b0, ev});
        chk("m_if_pc",     if_pc, ep);
        chk("m_if_instr",  if_instr, ei);
        chk("m_misalign",  {31'b0, misalign_err}, {31'b0, m_err});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic pulse_redirect(input logic [31:0] pc);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        model_reset();
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b1;
        repeat (3) step();
        mid();
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_addr",  imem_addr, RESET_PC);
        step();
        rst_n = 1'b1;                                // C0
        step(); fetch_en = 1'b1;                     // C1
        mid();  chk("c1_valid", {31'b0, if_valid}, 32'd0);
        step(); mid();                               // C2
        chk("c2_req",  {31'b0, imem_req}, 32'd1);
        chk("c2_addr", imem_addr, 32'h0);
        step(); mid();                               // C3
        chk("c3_valid", {31'b0, if_valid}, 32'd1);
        chk("c3_pc",    if_pc, 32'h0);
        chk("c3_instr", if_instr, 32'h1357_DB97);
        chk("c3_addr",  imem_addr, 32'h4);
        step(); mid(); chk("c4_pc", if_pc, 32'h4);
        repeat (3) step();

        // Reset mid-stream, then back-pressure from the first fetch
        rst_n = 1'b0; fetch_en = 1'b0; if_ready = 1'b0;
        mid();
        chk("mrst_valid", {31'b0, if_valid}, 32'd0);
        chk("mrst_instr", if_instr, 32'h0);
        step(); rst_n = 1'b1;                        // C0
        step(); fetch_en = 1'b1;                     // C1
        step(); step(); step(); mid();               // C4
        chk("full_req", {31'b0, imem_req}, 32'd0);
        chk("full_pc",  if_pc, 32'h0);
        step(); mid();                               // C5
        chk("hold_pc",    if_pc, 32'h0);
        chk("hold_instr", if_instr, mem_word(32'h0));
        step(); if_ready = 1'b1;                     // C6
        mid(); chk("drain0", if_pc, 32'h0); chk("drain_addr", imem_addr, 32'h8);
        step(); mid(); chk("drain4", if_pc, 32'h4);
        step(); mid(); chk("drain8", if_pc, 32'h8);

        // Redirect while full
        step(); if_ready = 1'b0;
        pulse_redirect(32'h100);
        if_ready = 1'b1;
        mid();
        chk("rd_valid", {31'b0, if_valid}, 32'd0);
        chk("rd_addr",  imem_addr, 32'h100);
        step(); mid(); chk("rd_pc", if_pc, 32'h100);

        // Address wrap
        pulse_redirect(32'hFFFF_FFF8);
        step(); mid(); chk("wrap0", if_pc, 32'hFFFF_FFF8);
        step(); mid(); chk("wrap1", if_pc, 32'hFFFF_FFFC);
        step(); mid(); chk("wrap2", if_pc, 32'h0000_0000);

        // Pause and resume
        step(); fetch_en = 1'b0;
        step(); mid(); chk("pause_req", {31'b0, imem_req}, 32'd0);
        step();
        step(); fetch_en = 1'b1;
        step(); mid(); chk("resume_addr", imem_addr, 32'hC);
        repeat (3) step();

        // Misaligned redirect
        pulse_redirect(32'h102);
        mid();
`ifdef IFETCH_MISALIGN_CHK_EN
        chk("mis_err", {31'b0, misalign_err}, 32'd1);
        chk("mis_req", {31'b0, imem_req}, 32'd0);
        step(); mid(); chk("mis_valid", {31'b0, if_valid}, 32'd0);
`else
        chk("mis_addr", imem_addr, 32'h100);
        step(); mid(); chk("mis_pc", if_pc, 32'h100);
`endif
        pulse_redirect(32'h200);
        mid(); chk("al_err", {31'b0, misalign_err}, 32'd0);
        step(); mid(); chk("al_pc", if_pc, 32'h200);

        // Back-to-back redirects
        step(); redirect_valid = 1'b1; redirect_pc = 32'h300;
        step(); redirect_pc = 32'h400;
        step(); redirect_valid = 1'b0;
        mid(); chk("b2b_addr", imem_addr, 32'h400);
        step(); mid(); chk("b2b_pc", if_pc, 32'h400);

        // Redirect while idle
        step(); fetch_en = 1'b0;
        pulse_redirect(32'h500);
        mid(); chk("idle_rd_req", {31'b0, imem_req}, 32'd0);
        step(); fetch_en = 1'b1;
        step(); step(); mid(); chk("idle_rd_pc", if_pc, 32'h500);
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
